// File: rtl/frame_window_pingpong.sv
// Ping-pong frame store with a KxK window read port.
// A raster pixel stream fills one bank while a filter reads KxK windows from the
// other. Every pixel is written to K*K identical RAMs so that all taps of a window
// can be fetched in the same cycle. Taps that fall outside the frame are either
// mirrored, clamped or forced to zero, depending on PAD_MODE.
//
// Handshake rules: a pixel is taken on a rising edge only when wr_valid and
// wr_ready are both high. A window request is taken only when rd_req and rd_ready
// are both high and (rd_row, rd_col) lies inside the frame. Its window appears
// with win_valid exactly two cycles later. There is no output backpressure.
module frame_window_pingpong #(
    parameter int ROWS     = 128,
    parameter int COLS     = 128,
    parameter int PIX_W    = 10,
    parameter int K        = 7,
    parameter int PAD_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic                       wr_sof,
    input  logic [PIX_W-1:0]           wr_pixel,
    output logic                       wr_frame_done,
    output logic [1:0]                 frames_avail,
    input  logic                       rd_req,
    output logic                       rd_ready,
    input  logic [$clog2(ROWS)-1:0]    rd_row,
    input  logic [$clog2(COLS)-1:0]    rd_col,
    input  logic                       rd_release,
    output logic [PIX_W*K*K-1:0]       win_pixel,
    output logic                       win_valid
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int RS    = RW + 2;
    localparam int CS    = CW + 2;
    localparam int HALF  = (K - 1) / 2;
    localparam int NT    = K * K;
    localparam int FRAME = ROWS * COLS;
    localparam int DEPTH = 2 * FRAME;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [RW-1:0]        ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0]        COL_LAST = CW'(COLS - 1);
    localparam logic [RW:0]          ROWS_U   = (RW + 1)'(ROWS);
    localparam logic [CW:0]          COLS_U   = (CW + 1)'(COLS);
    localparam logic signed [RS-1:0] ROWS_S   = RS'(ROWS);
    localparam logic signed [CS-1:0] COLS_S   = CS'(COLS);
    localparam logic signed [RS-1:0] ROW_MAX  = RS'(ROWS - 1);
    localparam logic signed [CS-1:0] COL_MAX  = CS'(COLS - 1);
    localparam logic signed [RS-1:0] ROW_REFL = RS'(2 * ROWS - 1);
    localparam logic signed [CS-1:0] COL_REFL = CS'(2 * COLS - 1);

    // Linear RAM address of a pixel inside one of the two banks.
    function automatic logic [AW-1:0] mk_addr(input logic bank,
                                              input logic [RW-1:0] row,
                                              input logic [CW-1:0] col);
        logic [AW-1:0] base;
        base = bank ? AW'(FRAME) : AW'(0);
        return base + AW'(row) * AW'(COLS) + AW'(col);
    endfunction

    // Fold a signed row index back into the frame (mirror or clamp).
    function automatic logic [RW-1:0] map_row(input logic signed [RS-1:0] v);
        logic signed [RS-1:0] m;
        m = v;
        if (v[RS-1])
            m = (PAD_MODE == 0) ? ~v : '0;
        else if (v >= ROWS_S)
            m = (PAD_MODE == 0) ? (ROW_REFL - v) : ROW_MAX;
        return RW'(m);
    endfunction

    // Fold a signed column index back into the frame (mirror or clamp).
    function automatic logic [CW-1:0] map_col(input logic signed [CS-1:0] v);
        logic signed [CS-1:0] m;
        m = v;
        if (v[CS-1])
            m = (PAD_MODE == 0) ? ~v : '0;
        else if (v >= COLS_S)
            m = (PAD_MODE == 0) ? (COL_REFL - v) : COL_MAX;
        return CW'(m);
    endfunction

    logic             wr_bank;
    logic             rd_bank;
    logic [RW-1:0]    wr_row;
    logic [CW-1:0]    wr_col;
    logic [1:0]       avail_q;
    logic             done_q;

    logic             wr_acc;
    logic             wr_last;
    logic             wr_complete;
    logic             rel;
    logic             rd_acc;
    logic [RW-1:0]    wr_row_eff;
    logic [CW-1:0]    wr_col_eff;
    logic [AW-1:0]    wr_addr;

    logic             v_d1;
    logic [NT-1:0]    oob_vec;
    logic [NT-1:0]    mask_d1;
    logic [NT*PIX_W-1:0] ram_bus;
    logic [NT*PIX_W-1:0] win_next;

    assign wr_ready      = (avail_q != 2'd2);
    assign rd_ready      = (avail_q != 2'd0);
    assign frames_avail  = avail_q;
    assign wr_frame_done = done_q;

    // Accept decisions and the effective write position (a start-of-frame pixel goes to (0,0)).
    always_comb begin
        wr_acc      = wr_valid & wr_ready;
        wr_row_eff  = wr_sof ? '0 : wr_row;
        wr_col_eff  = wr_sof ? '0 : wr_col;
        wr_last     = (wr_row_eff == ROW_LAST) && (wr_col_eff == COL_LAST);
        wr_complete = wr_acc & wr_last;
        rel         = rd_release & rd_ready;
        rd_acc      = rd_req & rd_ready & ({1'b0, rd_row} < ROWS_U) & ({1'b0, rd_col} < COLS_U);
        wr_addr     = mk_addr(wr_bank, wr_row_eff, wr_col_eff);
    end

    // Raster write counters, write bank pointer and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= wr_complete;
            if (wr_acc) begin
                if (wr_last) begin
                    wr_row  <= '0;
                    wr_col  <= '0;
                    wr_bank <= ~wr_bank;
                end else if (wr_col_eff == COL_LAST) begin
                    wr_row <= wr_row_eff + 1'b1;
                    wr_col <= '0;
                end else begin
                    wr_row <= wr_row_eff;
                    wr_col <= wr_col_eff + 1'b1;
                end
            end
        end
    end

    // Completed-bank count and read bank pointer; completion and release cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            avail_q <= 2'd0;
            rd_bank <= 1'b0;
        end else begin
            if (rel)
                rd_bank <= ~rd_bank;
            case ({wr_complete, rel})
                2'b10:   avail_q <= avail_q + 2'd1;
                2'b01:   avail_q <= avail_q - 2'd1;
                default: avail_q <= avail_q;
            endcase
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            localparam logic signed [RS-1:0] OFF_R = RS'(i - HALF);
            localparam logic signed [CS-1:0] OFF_C = CS'(j - HALF);

            logic signed [RS-1:0] tr;
            logic signed [CS-1:0] tc;
            logic [RW-1:0]        mr;
            logic [CW-1:0]        mc;
            logic                 oob;
            logic [AW-1:0]        rd_addr;
            logic [PIX_W-1:0]     mem [DEPTH];
            logic [PIX_W-1:0]     ram_q;

            // Tap coordinate, padding fold and read address for this tap.
            always_comb begin
                tr      = $signed({2'b00, rd_row}) + OFF_R;
                tc      = $signed({2'b00, rd_col}) + OFF_C;
                oob     = tr[RS-1] || (tr >= ROWS_S) || tc[CS-1] || (tc >= COLS_S);
                mr      = map_row(tr);
                mc      = map_col(tc);
                rd_addr = mk_addr(rd_bank, mr, mc);
            end

            // Every accepted pixel lands in every tap RAM at the same address.
            always_ff @(posedge clk) begin
                if (wr_acc && !rst)
                    mem[wr_addr] <= wr_pixel;
            end

            // Registered RAM read.
            always_ff @(posedge clk) begin
                ram_q <= mem[rd_addr];
            end

            assign ram_bus[(i*K+j)*PIX_W +: PIX_W] = ram_q;
            assign oob_vec[i*K+j] = (PAD_MODE == 2) && oob;
        end
    end

    // Zero-padding mask travels alongside the RAM read stage.
    always_ff @(posedge clk) begin
        mask_d1 <= oob_vec;
    end

    // Apply the zero mask to the RAM outputs.
    always_comb begin
        win_next = '0;
        for (int t = 0; t < NT; t++)
            win_next[t*PIX_W +: PIX_W] = mask_d1[t] ? '0 : ram_bus[t*PIX_W +: PIX_W];
    end

    // Valid pipeline and output register; reset drops in-flight requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_d1      <= 1'b0;
            win_valid <= 1'b0;
            win_pixel <= '0;
        end else begin
            v_d1      <= rd_acc;
            win_valid <= v_d1;
            if (v_d1)
                win_pixel <= win_next;
        end
    end

endmodule

// File: tb/tb_frame_window_pingpong.sv
// Bench for frame_window_pingpong: three instances (one per padding mode) share
// the same stimulus. A frame-queue model predicts control outputs every cycle and
// every window; fixed vectors and hand sequences cover the listed corner cases.
module tb_frame_window_pingpong;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int PIX_W = 10;
    localparam int K     = 3;
    localparam int HALF  = 1;
    localparam int NT    = K * K;
    localparam int WW    = PIX_W * NT;
    localparam int FP    = ROWS * COLS;
    localparam int RW    = 3;
    localparam int CW    = 3;

    typedef logic [FP*PIX_W-1:0] frame_t;
    typedef struct {
        int            mode;
        int            row;
        int            col;
        logic [WW-1:0] taps;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_sof;
    logic [PIX_W-1:0]  wr_pixel;
    logic              rd_req;
    logic [RW-1:0]     rd_row;
    logic [CW-1:0]     rd_col;
    logic              rd_release;

    logic [2:0]        wr_ready_v;
    logic [2:0]        wr_frame_done_v;
    logic [2:0]        rd_ready_v;
    logic [2:0]        win_valid_v;
    logic [1:0]        frames_avail_v [3];
    logic [WW-1:0]     win_pixel_v [3];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        frame_window_pingpong #(
            .ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .K(K), .PAD_MODE(m)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .wr_valid      (wr_valid),
            .wr_ready      (wr_ready_v[m]),
            .wr_sof        (wr_sof),
            .wr_pixel      (wr_pixel),
            .wr_frame_done (wr_frame_done_v[m]),
            .frames_avail  (frames_avail_v[m]),
            .rd_req        (rd_req),
            .rd_ready      (rd_ready_v[m]),
            .rd_row        (rd_row),
            .rd_col        (rd_col),
            .rd_release    (rd_release),
            .win_pixel     (win_pixel_v[m]),
            .win_valid     (win_valid_v[m])
        );
    end

    // ---------------- scoreboard / reference model ----------------
    frame_t        fq[$];          // completed, unreleased frames; front is being read
    frame_t        cur;            // frame under construction
    int            wpos = 0;       // next raster position in cur
    bit            exp_done = 0;
    bit            pend_v = 0;
    logic [WW-1:0] exp_q[$];       // windows (3 per request) due next cycle
    bit            last_wacc;
    int            done_cnt = 0;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic int fold(input int v, input int n, input int mode);
        if (mode == 0) begin
            if (v < 0) return -v - 1;
            if (v >= n) return 2 * n - 1 - v;
            return v;
        end
        if (v < 0) return 0;
        if (v >= n) return n - 1;
        return v;
    endfunction

    function automatic logic [WW-1:0] ref_win(input frame_t f, input int row, input int col,
                                              input int mode);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                int r, c, t;
                r = row - HALF + i;
                c = col - HALF + j;
                t = i * K + j;
                if (mode == 2 && (r < 0 || r >= ROWS || c < 0 || c >= COLS))
                    w[t*PIX_W +: PIX_W] = '0;
                else
                    w[t*PIX_W +: PIX_W] =
                        f[(fold(r, ROWS, mode) * COLS + fold(c, COLS, mode)) * PIX_W +: PIX_W];
            end
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] mk9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
        logic [WW-1:0] w;
        w = {PIX_W'(a8), PIX_W'(a7), PIX_W'(a6), PIX_W'(a5), PIX_W'(a4),
             PIX_W'(a3), PIX_W'(a2), PIX_W'(a1), PIX_W'(a0)};
        return w;
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- one clock cycle with model update and checks ----------------
    task automatic tick();
        bit            wacc, racc, rel, comp, exp_v_now;
        logic [WW-1:0] nw [3];
        logic [WW-1:0] ew;
        wacc = 0; racc = 0; rel = 0; comp = 0;
        for (int m = 0; m < 3; m++) nw[m] = '0;
        if (rst) begin
            fq.delete();
            wpos = 0;
            exp_q.delete();
            exp_v_now = 0;
        end else begin
            exp_v_now = pend_v;
            wacc = wr_valid && (fq.size() != 2);
            racc = rd_req && (fq.size() != 0);
            rel  = rd_release && (fq.size() != 0);
            if (racc)
                for (int m = 0; m < 3; m++) nw[m] = ref_win(fq[0], int'(rd_row), int'(rd_col), m);
            if (wacc) begin
                if (wr_sof) wpos = 0;
                cur[wpos*PIX_W +: PIX_W] = wr_pixel;
                wpos++;
                if (wpos == FP) begin
                    comp = 1;
                    wpos = 0;
                end
            end
            if (rel) void'(fq.pop_front());
            if (comp) fq.push_back(cur);
        end
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("win_valid[m%0d]", m), WW'(win_valid_v[m]), WW'(exp_v_now));
            if (exp_v_now) begin
                ew = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                chk($sformatf("win_pixel[m%0d]", m), win_pixel_v[m], ew);
            end
        end
        pend_v = racc;
        if (racc) for (int m = 0; m < 3; m++) exp_q.push_back(nw[m]);
        exp_done = comp;
        last_wacc = wacc;
        if (wr_frame_done_v[0]) done_cnt++;
        chk("wr_frame_done", WW'(wr_frame_done_v[0]), WW'(exp_done));
        chk("wr_ready", WW'(wr_ready_v[0]), WW'(fq.size() != 2));
        chk("rd_ready", WW'(rd_ready_v[0]), WW'(fq.size() != 0));
        for (int m = 0; m < 3; m++)
            chk($sformatf("frames_avail[m%0d]", m), WW'(frames_avail_v[m]), WW'(fq.size()));
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_pixels(input int base, input int n, input bit sof_first, input bit rnd);
        int p = 0;
        int budget = 0;
        while (p < n && budget < 400) begin
            wr_valid = 1'b1;
            wr_sof   = sof_first && (p == 0);
            wr_pixel = rnd ? PIX_W'($urandom_range(0, 1023)) : PIX_W'(base + p);
            tick();
            budget++;
            if (last_wacc) p++;
        end
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        if (p < n) fail_now("write_stall");
    endtask

    task automatic read_one(input int row, input int col);
        rd_req = 1'b1;
        rd_row = RW'(row);
        rd_col = CW'(col);
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl [7];
    int   d0;

    initial begin
        tbl[0] = '{0, 0, 0, mk9(0, 0, 1, 0, 0, 1, 8, 8, 9)};
        tbl[1] = '{0, 7, 7, mk9(54, 55, 55, 62, 63, 63, 62, 63, 63)};
        tbl[2] = '{2, 0, 7, mk9(0, 0, 0, 6, 7, 0, 14, 15, 0)};
        tbl[3] = '{1, 7, 0, mk9(48, 48, 49, 56, 56, 57, 56, 56, 57)};
        tbl[4] = '{1, 0, 0, mk9(0, 0, 1, 0, 0, 1, 8, 8, 9)};
        tbl[5] = '{2, 3, 3, mk9(18, 19, 20, 26, 27, 28, 34, 35, 36)};
        tbl[6] = '{0, 4, 0, mk9(24, 24, 25, 32, 32, 33, 40, 40, 41)};

        rst = 1'b1; wr_valid = 1'b0; wr_sof = 1'b0; wr_pixel = '0;
        rd_req = 1'b0; rd_row = '0; rd_col = '0; rd_release = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        for (int m = 0; m < 3; m++)
            chk($sformatf("reset_win_pixel[m%0d]", m), win_pixel_v[m], '0);
        tick();

        // One full frame: done pulse right after the 64th pixel.
        write_pixels(0, FP, 1'b0, 1'b0);
        chk("t1_done_pulse", WW'(wr_frame_done_v[0]), WW'(1));
        chk("t1_frames_avail", WW'(frames_avail_v[0]), WW'(1));
        tick();
        chk("t1_done_gone", WW'(wr_frame_done_v[0]), WW'(0));

        // Fixed windows with exact two-cycle latency.
        for (int v = 0; v < 7; v++) begin
            rd_req = 1'b1;
            rd_row = RW'(tbl[v].row);
            rd_col = CW'(tbl[v].col);
            tick();
            rd_req = 1'b0;
            chk($sformatf("tbl%0d_early", v), WW'(win_valid_v[tbl[v].mode]), WW'(0));
            tick();
            chk($sformatf("tbl%0d_valid", v), WW'(win_valid_v[tbl[v].mode]), WW'(1));
            chk($sformatf("tbl%0d_taps", v), win_pixel_v[tbl[v].mode], tbl[v].taps);
        end

        // Second frame fills both banks; further writes stall.
        write_pixels(100, FP, 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_pixel = 10'd999;
        repeat (3) begin
            tick();
            chk("t4_stall", WW'(wr_ready_v[0]), WW'(0));
        end
        wr_valid = 1'b0;
        read_one(3, 3);
        chk("t4_centre_a", WW'(win_pixel_v[0][4*PIX_W +: PIX_W]), WW'(27));
        release_bank();
        chk("t4_ready_back", WW'(wr_ready_v[0]), WW'(1));
        read_one(3, 3);
        chk("t4_centre_b", WW'(win_pixel_v[0][4*PIX_W +: PIX_W]), WW'(127));
        release_bank();

        // Restart mid-frame: partial data discarded.
        write_pixels(500, 20, 1'b0, 1'b0);
        d0 = done_cnt;
        write_pixels(200, FP, 1'b1, 1'b0);
        tick();
        chk("t5_one_done", WW'(done_cnt - d0), WW'(1));
        read_one(0, 0);
        chk("t5_centre", WW'(win_pixel_v[0][4*PIX_W +: PIX_W]), WW'(200));

        // Reset one cycle after an accepted request drops it.
        rd_req = 1'b1; rd_row = '0; rd_col = '0;
        tick();
        rd_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int m = 0; m < 3; m++)
            chk($sformatf("t6_no_valid[m%0d]", m), WW'(win_valid_v[m]), WW'(0));
        chk("t6_avail", WW'(frames_avail_v[0]), WW'(0));
        chk("t6_rd_ready", WW'(rd_ready_v[0]), WW'(0));

        // Random traffic against the frame-queue model.
        write_pixels(0, FP, 1'b0, 1'b1);
        for (int n = 0; n < 1500; n++) begin
            wr_valid   = ($urandom_range(0, 3) != 0);
            wr_sof     = ($urandom_range(0, 99) == 0);
            wr_pixel   = PIX_W'($urandom_range(0, 1023));
            rd_req     = $urandom_range(0, 1) == 1;
            rd_row     = RW'($urandom_range(0, ROWS - 1));
            rd_col     = CW'($urandom_range(0, COLS - 1));
            rd_release = ($urandom_range(0, 39) == 0);
            tick();
        end
        wr_valid = 1'b0; wr_sof = 1'b0; rd_req = 1'b0; rd_release = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
